// File: rtl/st7735_spi_tx.sv
// SPI write engine for ST7735-class panels: panel reset sequencing, then 8/16-bit
// command/data words serialised MSB first in SPI mode 0 with burst CS framing.
module st7735_spi_tx #(
  parameter int CLK_DIV           = 2,
  parameter int RESET_LOW_CYCLES  = 120,
  parameter int RESET_WAIT_CYCLES = 1440000,
  parameter int CS_GAP_CYCLES     = 2
) (
  input  logic        SYSTEM_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [15:0] IN_DATA,
  input  logic        IN_WIDE,
  input  logic        IN_DC,
  input  logic        IN_LAST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        REINIT,
  output logic        INIT_DONE,
  output logic        BUSY,
  output logic        CS,
  output logic        DC,
  output logic        LCD_CLK,
  output logic        MOSI,
  output logic        LCD_RESET
);
  // Handshake: a word transfers on a rising edge where IN_VALID && IN_READY;
  // IN_READY is combinational and never depends on IN_VALID.

  localparam int MAX_A = (CLK_DIV > CS_GAP_CYCLES) ? CLK_DIV : CS_GAP_CYCLES;
  localparam int MAX_B = (RESET_LOW_CYCLES > RESET_WAIT_CYCLES) ? RESET_LOW_CYCLES : RESET_WAIT_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] C_DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_LOW_M1  = CW'(RESET_LOW_CYCLES - 1);
  localparam logic [CW-1:0] C_WAIT_M1 = CW'(RESET_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] C_GAP_M1  = CW'(CS_GAP_CYCLES - 1);

  typedef enum logic [2:0] {ST_RST_LOW, ST_RST_WAIT, ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [3:0]    r_bit, w_bit;
  logic [15:0]   r_shreg, w_shreg;
  logic          r_last, w_last;
  logic          r_dc, w_dc;
  logic          r_cs, w_cs;
  logic          r_sck, w_sck;
  logic          r_mosi, w_mosi;
  logic          r_lcd_reset, w_lcd_reset;
  logic          r_init_done, w_init_done;
  logic          w_accept;

  assign IN_READY  = (r_state == ST_IDLE) && !REINIT;
  assign w_accept  = IN_VALID && IN_READY;
  assign BUSY      = !((r_state == ST_IDLE) && r_cs);
  assign INIT_DONE = r_init_done;
  assign CS        = r_cs;
  assign DC        = r_dc;
  assign LCD_CLK   = r_sck;
  assign MOSI      = r_mosi;
  assign LCD_RESET = r_lcd_reset;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_bit       = r_bit;
    w_shreg     = r_shreg;
    w_last      = r_last;
    w_dc        = r_dc;
    w_cs        = r_cs;
    w_sck       = r_sck;
    w_mosi      = r_mosi;
    w_lcd_reset = r_lcd_reset;
    w_init_done = r_init_done;
    case (r_state)
      ST_RST_LOW: begin
        if (r_cnt == C_LOW_M1) begin
          w_cnt       = '0;
          w_lcd_reset = 1'b1;
          w_state     = ST_RST_WAIT;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_RST_WAIT: begin
        if (r_cnt == C_WAIT_M1) begin
          w_cnt       = '0;
          w_init_done = 1'b1;
          w_state     = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (REINIT) begin
          // Closes any open burst in the same transition as the reset restarts.
          w_state     = ST_RST_LOW;
          w_cnt       = '0;
          w_cs        = 1'b1;
          w_sck       = 1'b0;
          w_mosi      = 1'b0;
          w_lcd_reset = 1'b0;
          w_init_done = 1'b0;
        end else if (w_accept) begin
          w_state = ST_SHIFT;
          w_cnt   = '0;
          w_shreg = IN_WIDE ? IN_DATA : {IN_DATA[7:0], 8'h00};
          w_mosi  = IN_WIDE ? IN_DATA[15] : IN_DATA[7];
          w_bit   = IN_WIDE ? 4'd15 : 4'd7;
          w_last  = IN_LAST;
          w_dc    = IN_DC;
          w_cs    = 1'b0;
          w_sck   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (r_cnt != C_DIV_M1) begin
          w_cnt = r_cnt + CW'(1);
        end else if (!r_sck) begin
          w_cnt = '0;
          w_sck = 1'b1;
        end else begin
          // End of a high phase: advance to the next bit or finish the word.
          w_cnt = '0;
          w_sck = 1'b0;
          if (r_bit == 4'd0) begin
            if (r_last) begin
              w_cs    = 1'b1;
              w_state = ST_GAP;
            end else begin
              w_state = ST_IDLE;
            end
          end else begin
            w_bit   = r_bit - 4'd1;
            w_shreg = {r_shreg[14:0], 1'b0};
            w_mosi  = r_shreg[14];
          end
        end
      end
      ST_GAP: begin
        if (r_cnt == C_GAP_M1) begin
          w_cnt   = '0;
          w_state = ST_IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_state = ST_RST_LOW;
    endcase
  end

  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      r_state     <= ST_RST_LOW;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_last      <= 1'b0;
      r_dc        <= 1'b0;
      r_cs        <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_lcd_reset <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit       <= w_bit;
      r_shreg     <= w_shreg;
      r_last      <= w_last;
      r_dc        <= w_dc;
      r_cs        <= w_cs;
      r_sck       <= w_sck;
      r_mosi      <= w_mosi;
      r_lcd_reset <= w_lcd_reset;
      r_init_done <= w_init_done;
    end
  end
endmodule

// File: tb/tb_st7735_spi_tx.sv
// Directed bench for st7735_spi_tx: reset sequencing, single words, bursts,
// fast SCK, reset mid-word and REINIT handling, against hand-computed values.
module tb_st7735_spi_tx;
  localparam int LOW_C  = 4;
  localparam int WAIT_C = 10;
  localparam int GAP_C  = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic [15:0] in_data = '0;
  logic in_wide = 1'b0, in_dc = 1'b0, in_last = 1'b0, in_valid = 1'b0, reinit = 1'b0;
  logic in_ready, init_done, busy, cs, dc, lcd_clk, mosi, lcd_reset;

  logic [15:0] f_data = '0;
  logic f_wide = 1'b0, f_dc = 1'b0, f_last = 1'b0, f_valid = 1'b0, f_reinit = 1'b0;
  logic f_ready, f_init_done, f_busy, f_cs, f_dc_o, f_sck, f_mosi, f_lcd_reset;

  st7735_spi_tx #(.CLK_DIV(2), .RESET_LOW_CYCLES(LOW_C), .RESET_WAIT_CYCLES(WAIT_C),
                  .CS_GAP_CYCLES(GAP_C)) u_dut (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .IN_DATA(in_data), .IN_WIDE(in_wide),
    .IN_DC(in_dc), .IN_LAST(in_last), .IN_VALID(in_valid), .IN_READY(in_ready),
    .REINIT(reinit), .INIT_DONE(init_done), .BUSY(busy), .CS(cs), .DC(dc),
    .LCD_CLK(lcd_clk), .MOSI(mosi), .LCD_RESET(lcd_reset));

  st7735_spi_tx #(.CLK_DIV(1), .RESET_LOW_CYCLES(LOW_C), .RESET_WAIT_CYCLES(WAIT_C),
                  .CS_GAP_CYCLES(GAP_C)) u_fast (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .IN_DATA(f_data), .IN_WIDE(f_wide),
    .IN_DC(f_dc), .IN_LAST(f_last), .IN_VALID(f_valid), .IN_READY(f_ready),
    .REINIT(f_reinit), .INIT_DONE(f_init_done), .BUSY(f_busy), .CS(f_cs), .DC(f_dc_o),
    .LCD_CLK(f_sck), .MOSI(f_mosi), .LCD_RESET(f_lcd_reset));

  // scoreboard: {dc, mosi} at each rising LCD_CLK
  logic [1:0] exp_q[$];
  logic [1:0] cap_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic prev_sck = 1'b0;
  logic [1:0] held = '0;
  int glitch = 0;
  int watch = 0;
  int cs_broke = 0;
  always @(negedge clk) begin
    if (lcd_clk && !prev_sck) begin
      cap_q.push_back({dc, mosi});
      held = {dc, mosi};
    end else if (lcd_clk && ({dc, mosi} != held)) begin
      glitch++;
    end
    prev_sck = lcd_clk;
    if (watch != 0 && cs) cs_broke++;
  end

  logic acc_s, old_dc_s, rst_s;
  int dc_bad = 0;
  always @(posedge clk) begin
    acc_s    = in_valid && in_ready;
    old_dc_s = dc;
    rst_s    = rst;
    #1;
    if (dc !== old_dc_s && !acc_s && !rst_s) dc_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic w, input logic dv, input logic l);
    in_data  = d;
    in_wide  = w;
    in_dc    = dv;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    fail_now("accept");
  endtask

  task automatic push_exp(input logic [15:0] d, input logic w, input logic dv);
    for (int i = (w ? 15 : 7); i >= 0; i--) exp_q.push_back({dv, d[i]});
  endtask

  task automatic compare_caps(input string tag);
    logic [1:0] e, a;
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      a = cap_q.pop_front();
      check({tag, "_bit"}, a, e);
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  task automatic wait_cs_high(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cs && n < 500);
    if (!cs) fail_now("cs_high");
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      tick();
      n++;
    end
    if (!init_done) fail_now(tag);
  endtask

  int n, bad, rises;
  logic p;

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_lcd_reset", lcd_reset, 0);
    check("rst_cs", cs, 1);
    check("rst_lcd_clk", lcd_clk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_dc", dc, 0);
    check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 1);
    check("rst_in_ready", in_ready, 0);

    // reset sequence timing
    rst = 1'b0;
    n = 0;
    bad = 0;
    do begin
      tick();
      n++;
      if (in_ready || !cs || lcd_clk) bad++;
    end while (!lcd_reset && n < 100);
    check("rst_low_len", n, LOW_C);
    n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
      if ((in_ready && !init_done) || !cs || lcd_clk || !lcd_reset) bad++;
    end
    check("rst_wait_len", n, WAIT_C);
    check("init_quiet", bad, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 1);

    // single command word 0x2A
    cap_q.delete();
    push_exp(16'h002A, 1'b0, 1'b0);
    send_word(16'h002A, 1'b0, 1'b0, 1'b1);
    check("w2A_cs_low", cs, 0);
    wait_cs_high(n);
    check("w2A_shift_len", n, 32);
    n = 0;
    bad = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
      if (!cs) bad++;
    end
    check("w2A_gap_len", n, GAP_C);
    check("w2A_gap_cs", bad, 0);
    compare_caps("w2A");

    // burst: 0x2C command then 16-bit 0xF81F data
    push_exp(16'h002C, 1'b0, 1'b0);
    push_exp(16'hF81F, 1'b1, 1'b1);
    send_word(16'h002C, 1'b0, 1'b0, 1'b0);
    watch = 1;
    send_word(16'hF81F, 1'b1, 1'b1, 1'b1);
    check("burst_dc_second", dc, 1);
    wait_cs_high(n);
    watch = 0;
    check("burst_word2_len", n, 64);
    check("burst_cs_held", cs_broke, 0);
    compare_caps("burst");

    // CLK_DIV=1 instance, 0xFF
    f_data  = 16'h00FF;
    f_wide  = 1'b0;
    f_dc    = 1'b1;
    f_last  = 1'b1;
    f_valid = 1'b1;
    n = 0;
    while (!f_ready && n < 100) begin
      tick();
      n++;
    end
    if (!f_ready) fail_now("fast_ready");
    tick();
    f_valid = 1'b0;
    check("fast_cs_low", f_cs, 0);
    check("fast_sck_start", f_sck, 0);
    n = 1;
    bad = 0;
    rises = 0;
    p = f_sck;
    do begin
      tick();
      n++;
      if (f_sck == p) bad++;
      if (f_sck && !p) rises++;
      p = f_sck;
    end while (!f_cs && n < 100);
    check("fast_word_len", n, 17);
    check("fast_toggle", bad, 0);
    check("fast_rises", rises, 8);

    // reset during bit 3 of 0xA5
    cap_q.delete();
    send_word(16'h00A5, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (cap_q.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cap_q.size() < 5) fail_now("a5_bit3");
    check("a5_bit3_val", cap_q[4], 2'b10);
    rst = 1'b1;
    tick();
    check("mid_rst_cs", cs, 1);
    check("mid_rst_sck", lcd_clk, 0);
    check("mid_rst_lcd_reset", lcd_reset, 0);
    check("mid_rst_init_done", init_done, 0);
    cap_q.delete();
    rst = 1'b0;
    wait_init("mid_rst_init");
    check("mid_rst_no_edges", cap_q.size(), 0);

    // REINIT in IDLE during an open burst
    push_exp(16'h0011, 1'b0, 1'b0);
    send_word(16'h0011, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("open_burst_cs", cs, 0);
    compare_caps("w11");
    in_data  = 16'h0022;
    in_wide  = 1'b0;
    in_dc    = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    reinit   = 1'b1;
    #1;
    check("reinit_ready", in_ready, 0);
    tick();
    reinit = 1'b0;
    check("reinit_cs", cs, 1);
    check("reinit_lcd_reset", lcd_reset, 0);
    check("reinit_init_done", init_done, 0);
    check("reinit_busy", busy, 1);
    wait_init("reinit_init");
    check("reinit_no_edges", cap_q.size(), 0);
    check("reinit_ready_after", in_ready, 1);
    push_exp(16'h0022, 1'b0, 1'b1);
    send_word(16'h0022, 1'b0, 1'b1, 1'b1);
    repeat (3) tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    wait_cs_high(n);
    check("shift_reinit_lcd_reset", lcd_reset, 1);
    check("shift_reinit_init_done", init_done, 1);
    compare_caps("w22");
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("final_ready", in_ready, 1);
    check("high_phase_stable", glitch, 0);
    check("dc_only_at_accept", dc_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/st7735_spi_tx.md
Name: st7735_spi_tx

Overview:
- Parametrised SPI write engine for ST7735-class TFT/OLED panels driven from the 12 MHz iCE40 system clock.
- Sequences the panel hardware reset, then serialises command and data words (8- or 16-bit, selected per word) under a valid/ready handshake.
- Drives CS, DC, LCD_CLK, MOSI and the panel reset line.
- Sits between the display controller and the panel pins; successor to the fixed-function ST7735 driver. Adds configurable SCK rate, per-word width, burst framing with IN_LAST, and a re-init request.

Parameters:
- CLK_DIV, 2: system clocks per LCD_CLK half-period; must be >= 1.
- RESET_LOW_CYCLES, 120: system clocks LCD_RESET is held low.
- RESET_WAIT_CYCLES, 1440000: system clocks after LCD_RESET rises before INIT_DONE (120 ms at 12 MHz).
- CS_GAP_CYCLES, 2: minimum system clocks CS stays high between frames; must be >= 1.

Ports:
- SYSTEM_CLK  in  1  system clock; all logic on its rising edge.
- SYSTEM_RESET  in  1  synchronous, active-high reset.
- IN_DATA  in  16  word to send; [7:0] only when IN_WIDE=0.
- IN_WIDE  in  1  1 = send 16 bits, 0 = send 8 bits.
- IN_DC  in  1  DC level for this word (0 command, 1 data).
- IN_LAST  in  1  release CS after this word.
- IN_VALID  in  1  word present.
- IN_READY  out  1  engine accepts a word this cycle.
- REINIT  in  1  single-cycle request to rerun the panel reset sequence.
- INIT_DONE  out  1  panel reset sequence complete.
- BUSY  out  1  high in every state except IDLE with CS high.
- CS  out  1  chip select, active low.
- DC  out  1  data/command.
- LCD_CLK  out  1  SPI clock, mode 0 (idle low, panel samples on rising edge).
- MOSI  out  1  serial data, MSB first.
- LCD_RESET  out  1  panel hardware reset, active low.

Behaviour:
- **States:** RST_LOW, RST_WAIT, IDLE, SHIFT, GAP.
- **Reset values** (SYSTEM_RESET=1, any state, including mid-word):
  - state=RST_LOW, LCD_RESET=0, CS=1, LCD_CLK=0, MOSI=0, DC=0, INIT_DONE=0, BUSY=1.
  - The current word is discarded.
- **RST_LOW:** hold LCD_RESET=0 for exactly RESET_LOW_CYCLES cycles, then LCD_RESET=1 and go to RST_WAIT.
- **RST_WAIT:** hold for exactly RESET_WAIT_CYCLES cycles, then go to IDLE with INIT_DONE=1.
- **IN_READY:** combinational, (state==IDLE) && !REINIT. It is 0 in every other state, so IN_VALID outside IDLE is ignored.
- **Accept (IDLE):** on IN_VALID && IN_READY, latch IN_DATA/IN_WIDE/IN_DC/IN_LAST; bit count N = 16 if IN_WIDE else 8.
  - Next cycle: state=SHIFT, CS=0, DC=latched DC, MOSI=bit N-1, LCD_CLK=0.
- **SHIFT**, each bit in turn:
  - LCD_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI updates to the next bit on the high-to-low transition.
  - DC and MOSI are stable for the whole high phase.
- **Bit timing:**
  - Word occupies 2*CLK_DIV*N cycles in SHIFT.
  - An accepted word completes 1 + 2*CLK_DIV*N cycles after the accept edge.
  - After the last high phase, LCD_CLK=0.
- **End of word:**
  - IN_LAST=0: go to IDLE with CS held 0. A new word may be accepted that cycle (back-to-back; LCD_CLK gap = 1 idle-low cycle plus the CLK_DIV low phase).
  - IN_LAST=1: CS=1, go to GAP for CS_GAP_CYCLES cycles, then IDLE.
- **DC changes:** DC changes only at an accept edge, never while LCD_CLK=1 or within a word.
- **REINIT:** honoured only in IDLE.
  - If CS=0 (open burst), CS goes to 1 in the same transition.
  - Then goes to RST_LOW; INIT_DONE=0 until the sequence completes.
  - REINIT in any other state is ignored, not queued.
- **Counters:** sized from clog2 of the largest parameter and never wrap. Bit counter counts down from N-1 to 0.

Test Plan:
- Reset release, RESET_LOW_CYCLES=4, RESET_WAIT_CYCLES=10 -> LCD_RESET=0 for 4 cycles then 1; INIT_DONE rises 10 cycles later; IN_READY=0 throughout; CS=1, LCD_CLK=0.
- CLK_DIV=2, one word 0x2A, IN_DC=0, IN_LAST=1 -> CS low for 32 SHIFT cycles; 8 rising LCD_CLK edges sample 0,0,1,0,1,0,1,0; DC=0; then CS=1 for exactly CS_GAP_CYCLES before IN_READY returns.
- Burst: 0x2C (DC=0, LAST=0) then 16-bit 0xF81F (DC=1, WIDE=1, LAST=1) presented back-to-back -> CS stays low across both words; 24 rising edges total; DC switches 0 to 1 only at the second accept; the second word's bits are 1111100000011111.
- CLK_DIV=1, 8-bit word 0xFF -> LCD_CLK toggles every cycle; word completes 17 cycles after accept.
- SYSTEM_RESET asserted mid-word (bit 3 of 0xA5) -> next cycle CS=1, LCD_CLK=0, LCD_RESET=0, INIT_DONE=0; no further LCD_CLK edges until the reset sequence completes.
- REINIT together with IN_VALID in IDLE during an open burst -> word not accepted (IN_READY=0), CS rises, reset sequence reruns; the word is accepted after INIT_DONE. REINIT during SHIFT is ignored.
